trdb_branch_map: RTL and testbench

- Upstream stage of the packet-format selector.
- Records the outcome of every qualified retired conditional branch into a bit map plus count.
- Exports full/empty status, and the map/count that the packet emitter copies into format 1/3 payloads.
- Cleared when the emitter reports that a packet carrying the map has been sent.

---
 rtl/trdb_branch_map.sv | 81 ++++++++
 tb/tb_trdb_branch_map.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/trdb_branch_map.sv
// Branch map recorder: collects retired conditional branch outcomes for the packet emitter.
// Optional sticky overflow flag enabled by TRDB_BRANCH_MAP_OVERFLOW_EN.
module trdb_branch_map #(
    parameter int MAP_LEN = 31,
    localparam int CNT_W = $clog2(MAP_LEN + 1)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               valid_i,
    input  logic               is_branch_i,
    input  logic               branch_taken_i,
    input  logic               flush_i,
    output logic [MAP_LEN-1:0] map_o,
    output logic [CNT_W-1:0]   branches_o,
    output logic               is_full_o,
    output logic               is_empty_o,
    output logic               overflow_o
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAP_LEN);

    logic [MAP_LEN-1:0] map_q, map_n, bit_v;
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    logic               record;
    logic               full;

    assign record = valid_i & is_branch_i;
    assign full   = (cnt_q == FULL_CNT);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            map_q <= '0;
            cnt_q <= '0;
        end else begin
            map_q <= map_n;
            cnt_q <= cnt_n;
        end
    end

    // A flush clears first, so a coincident record lands at bit 0.
    always_comb begin
        map_n    = map_q;
        cnt_n    = cnt_q;
        bit_v    = '0;
        bit_v[0] = ~branch_taken_i;
        if (flush_i) begin
            map_n = record ? bit_v : '0;
            cnt_n = record ? CNT_W'(1) : '0;
        end else if (record && !full) begin
            map_n = map_q | (bit_v << cnt_q);
            cnt_n = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        map_o      = map_q;
        branches_o = cnt_q;
        is_full_o  = full;
        is_empty_o = (cnt_q == '0);
    end

`ifdef TRDB_BRANCH_MAP_OVERFLOW_EN
    logic ovf_q;
    logic drop;

    assign drop = record & ~flush_i & full;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ovf_q <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
        end
    end

    assign overflow_o = ovf_q;
`else
    assign overflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_trdb_branch_map.sv
// Directed bench for trdb_branch_map with a reference-model scoreboard.
// Expects overflow behaviour matching TRDB_BRANCH_MAP_OVERFLOW_EN.
module tb_trdb_branch_map;

    localparam int ML = 31;
    localparam int CW = 5;

    logic          clk;
    logic          rst_ni;
    logic          valid_i;
    logic          is_branch_i;
    logic          branch_taken_i;
    logic          flush_i;
    logic [ML-1:0] map_o;
    logic [CW-1:0] branches_o;
    logic          is_full_o;
    logic          is_empty_o;
    logic          overflow_o;

    typedef struct {
        logic [ML-1:0] map;
        logic [CW-1:0] cnt;
        logic          full;
        logic          empty;
        logic          ovf;
    } exp_t;

    exp_t          sb[$];
    logic [ML-1:0] m_map;
    int            m_cnt;
    logic          m_ovf;
    int            tests;
    int            fails;
    logic [ML-1:0] held;

`ifdef TRDB_BRANCH_MAP_OVERFLOW_EN
    localparam logic OVF_EN = 1'b1;
`else
    localparam logic OVF_EN = 1'b0;
`endif

    trdb_branch_map #(.MAP_LEN(ML)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .valid_i        (valid_i),
        .is_branch_i    (is_branch_i),
        .branch_taken_i (branch_taken_i),
        .flush_i        (flush_i),
        .map_o          (map_o),
        .branches_o     (branches_o),
        .is_full_o      (is_full_o),
        .is_empty_o     (is_empty_o),
        .overflow_o     (overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_map = '0;
        m_cnt = 0;
        m_ovf = 1'b0;
    endtask

    // Drive one cycle, predict the registered result, compare after the edge.
    task automatic step(input logic v, input logic br, input logic tk,
                        input logic fl);
        exp_t e;
        logic rec;
        valid_i        = v;
        is_branch_i    = br;
        branch_taken_i = tk;
        flush_i        = fl;
        rec = v & br;
        if (fl) begin
            m_map = '0;
            m_cnt = 0;
            if (rec) begin
                m_map[0] = ~tk;
                m_cnt    = 1;
            end
        end else if (rec) begin
            if (m_cnt < ML) begin
                m_map[m_cnt] = ~tk;
                m_cnt++;
            end else if (OVF_EN) begin
                m_ovf = 1'b1;
            end
        end
        e.map   = m_map;
        e.cnt   = CW'(m_cnt);
        e.full  = (m_cnt == ML);
        e.empty = (m_cnt == 0);
        e.ovf   = m_ovf;
        sb.push_back(e);
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        flush_i = 1'b0;
        if (sb.size() == 0) begin
            chk("sb_underflow", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk("sb_map", 32'(map_o), 32'(e.map));
            chk("sb_cnt", 32'(branches_o), 32'(e.cnt));
            chk("sb_full", 32'(is_full_o), 32'(e.full));
            chk("sb_empty", 32'(is_empty_o), 32'(e.empty));
            chk("sb_ovf", 32'(overflow_o), 32'(e.ovf));
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_map"}, 32'(map_o), 32'd0);
        chk({tag, "_cnt"}, 32'(branches_o), 32'd0);
        chk({tag, "_full"}, 32'(is_full_o), 32'd0);
        chk({tag, "_empty"}, 32'(is_empty_o), 32'd1);
        chk({tag, "_ovf"}, 32'(overflow_o), 32'd0);
    endtask

    initial begin
        tests          = 0;
        fails          = 0;
        rst_ni         = 1'b0;
        valid_i        = 1'b0;
        is_branch_i    = 1'b0;
        branch_taken_i = 1'b0;
        flush_i        = 1'b0;
        model_reset();
        #12;
        chk_reset_vals("reset");
        rst_ni = 1'b1;
        @(posedge clk);
        #1;

        step(1, 1, 1, 0);
        step(1, 1, 0, 0);
        step(1, 1, 1, 0);
        chk("three_map", 32'(map_o), 32'b010);
        chk("three_cnt", 32'(branches_o), 32'd3);
        chk("three_empty", 32'(is_empty_o), 32'd0);
        chk("three_full", 32'(is_full_o), 32'd0);

        step(0, 0, 0, 1);
        for (int i = 0; i < ML; i++) begin
            step(1, 1, 0, 0);
            if (i == ML - 2) chk("fill30_full", 32'(is_full_o), 32'd0);
        end
        chk("fill_map", 32'(map_o), 32'h7FFF_FFFF);
        chk("fill_cnt", 32'(branches_o), 32'd31);
        chk("fill_full", 32'(is_full_o), 32'd1);

        step(1, 1, 1, 0);
        chk("drop_map", 32'(map_o), 32'h7FFF_FFFF);
        chk("drop_cnt", 32'(branches_o), 32'd31);
        chk("drop_ovf", 32'(overflow_o), 32'(OVF_EN));
        step(0, 0, 0, 1);
        chk("ovf_sticky", 32'(overflow_o), 32'(OVF_EN));

        step(1, 1, 1, 0);
        step(1, 1, 0, 0);
        step(1, 1, 1, 0);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        chk("five_map", 32'(map_o), 32'b11010);
        valid_i        = 1'b1;
        is_branch_i    = 1'b1;
        branch_taken_i = 1'b0;
        flush_i        = 1'b1;
        #1;
        chk("preflush_cnt", 32'(branches_o), 32'd5);
        step(1, 1, 0, 1);
        chk("flushrec_map", 32'(map_o), 32'd1);
        chk("flushrec_cnt", 32'(branches_o), 32'd1);

        for (int i = 0; i < 10; i++) begin
            step(0, 1, 1'($urandom_range(0, 1)), 0);
        end
        chk("idle_map", 32'(map_o), 32'd1);
        chk("idle_cnt", 32'(branches_o), 32'd1);
        step(0, 0, 0, 1);
        step(0, 1, 0, 1);
        chk("flush_empty", 32'(is_empty_o), 32'd1);
        chk("flush_empty_cnt", 32'(branches_o), 32'd0);

        for (int i = 0; i < 12; i++) begin
            step(1, 1, 1'(i % 3 == 0), 0);
        end
        chk("pre_rst_cnt", 32'(branches_o), 32'd12);
        held = map_o;
        chk("pre_rst_map", 32'(held), 32'h0000_0DB6);
        #2;
        flush_i = 1'b1;
        rst_ni  = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        model_reset();
        #2;
        flush_i = 1'b0;
        rst_ni  = 1'b1;
        @(posedge clk);
        #1;
        step(1, 1, 0, 0);
        chk("post_rst_map", 32'(map_o), 32'd1);
        chk("post_rst_cnt", 32'(branches_o), 32'd1);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
